// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the OTTER PC redirect controller.
package otter_pc_pkg;

    typedef enum logic [2:0] {
        SRC_PC4    = 3'd0,
        SRC_JALR   = 3'd1,
        SRC_BRANCH = 3'd2,
        SRC_JAL    = 3'd3,
        SRC_INTR   = 3'd4,
        SRC_MRET   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_INTR  = 2'd2
    } redir_state_t;

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Instruction fetch is word aligned; every loaded target drops bits [1:0].
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Bundle between EX-stage branch resolution / CSR file / IF and the PC controller.
// master: the pipeline side driving resolution results; slave: the controller.
interface pc_redirect_ctrl_if;
    logic        STALL;
    logic        EX_VALID;
    logic [31:0] EX_PC;
    logic [2:0]  PC_SOURCE;
    logic        INT_TAKEN;
    logic [31:0] JALR_TGT;
    logic [31:0] BRANCH_TGT;
    logic [31:0] JAL_TGT;
    logic [31:0] MTVEC;
    logic [31:0] MEPC_IN;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        KILL_ID;
    logic        KILL_EX;
    logic        KILL_MEM;
    logic        MEPC_WE;
    logic [31:0] MEPC_DATA;
    logic        INT_ACK;
    logic        BUSY;

    modport master (
        output STALL, EX_VALID, EX_PC, PC_SOURCE, INT_TAKEN,
               JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC_IN,
        input  PC, PC_PLUS4, KILL_ID, KILL_EX, KILL_MEM,
               MEPC_WE, MEPC_DATA, INT_ACK, BUSY
    );

    modport slave (
        input  STALL, EX_VALID, EX_PC, PC_SOURCE, INT_TAKEN,
               JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC_IN,
        output PC, PC_PLUS4, KILL_ID, KILL_EX, KILL_MEM,
               MEPC_WE, MEPC_DATA, INT_ACK, BUSY
    );
endinterface

// File: rtl/pc_redirect_ctrl_target_mux.sv
// Combinational next-target selection with word alignment.
import otter_pc_pkg::*;

module pc_target_mux (
    input  logic        int_sel_i,
    input  logic [2:0]  pc_source_i,
    input  logic [31:0] jalr_tgt_i,
    input  logic [31:0] branch_tgt_i,
    input  logic [31:0] jal_tgt_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_in_i,
    output logic [31:0] target_o,
    output logic        redirect_o
);
    logic [31:0] raw_tgt;

    // Interrupt vector wins; otherwise decode the control-transfer source.
    always_comb begin
        raw_tgt    = mtvec_i;
        redirect_o = 1'b0;
        if (!int_sel_i) begin
            case (pc_source_i)
                SRC_JALR:   begin raw_tgt = jalr_tgt_i;   redirect_o = 1'b1; end
                SRC_BRANCH: begin raw_tgt = branch_tgt_i; redirect_o = 1'b1; end
                SRC_JAL:    begin raw_tgt = jal_tgt_i;    redirect_o = 1'b1; end
                SRC_MRET:   begin raw_tgt = mepc_in_i;    redirect_o = 1'b1; end
                default:    begin raw_tgt = mtvec_i;      redirect_o = 1'b0; end
            endcase
        end
    end

    assign target_o = align_pc(raw_tgt);
endmodule

// File: rtl/pc_redirect_ctrl.sv
// Architectural PC owner: next-fetch selection, wrong-path squash and interrupt
// entry with MEPC capture. Optional transfer counters under OTTER_REDIRECT_CNT_EN.
//
//  state | meaning
//  RUN   | normal fetch; accepts redirects and interrupts
//  REDIR | one-cycle squash of ID/EX after a taken transfer
//  INTR  | one-cycle interrupt entry: squash ID/EX/MEM, write MEPC, ack
import otter_pc_pkg::*;

module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    pc_redirect_ctrl_if.slave    bus
`ifdef OTTER_REDIRECT_CNT_EN
    ,
    output logic [31:0]          REDIR_CNT,
    output logic [31:0]          INT_CNT
`endif
);
    redir_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  mepc_data_q, mepc_data_d;
    logic         kill_id_q, kill_id_d;
    logic         kill_ex_q, kill_ex_d;
    logic         kill_mem_q, kill_mem_d;
    logic         mepc_we_q, mepc_we_d;
    logic         int_ack_q, int_ack_d;

    logic [31:0]  target;
    logic         src_redirect;
    logic         int_accept;
    logic         redir_accept;

    pc_target_mux u_mux (
        .int_sel_i    (bus.INT_TAKEN),
        .pc_source_i  (bus.PC_SOURCE),
        .jalr_tgt_i   (bus.JALR_TGT),
        .branch_tgt_i (bus.BRANCH_TGT),
        .jal_tgt_i    (bus.JAL_TGT),
        .mtvec_i      (bus.MTVEC),
        .mepc_in_i    (bus.MEPC_IN),
        .target_o     (target),
        .redirect_o   (src_redirect)
    );

    // Transfers are only taken in RUN; a pending INT_TAKEN simply waits there.
    assign int_accept   = (state_q == ST_RUN) && bus.EX_VALID && bus.INT_TAKEN;
    assign redir_accept = (state_q == ST_RUN) && bus.EX_VALID && !bus.INT_TAKEN && src_redirect;

    // Next state, next PC and the registered one-shot outputs.
    always_comb begin
        state_d     = ST_RUN;
        pc_d        = pc_q;
        mepc_data_d = mepc_data_q;
        kill_id_d   = 1'b0;
        kill_ex_d   = 1'b0;
        kill_mem_d  = 1'b0;
        mepc_we_d   = 1'b0;
        int_ack_d   = 1'b0;
        if (int_accept) begin
            state_d     = ST_INTR;
            pc_d        = target;
            mepc_data_d = bus.EX_PC;
            kill_id_d   = 1'b1;
            kill_ex_d   = 1'b1;
            kill_mem_d  = 1'b1;
            mepc_we_d   = 1'b1;
            int_ack_d   = 1'b1;
        end else if (redir_accept) begin
            state_d   = ST_REDIR;
            pc_d      = target;
            kill_id_d = 1'b1;
            kill_ex_d = 1'b1;
        end else if (!bus.STALL) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // State, PC and output registers; reset aborts any in-flight entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_VEC;
            mepc_data_q <= 32'd0;
            kill_id_q   <= 1'b0;
            kill_ex_q   <= 1'b0;
            kill_mem_q  <= 1'b0;
            mepc_we_q   <= 1'b0;
            int_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mepc_data_q <= mepc_data_d;
            kill_id_q   <= kill_id_d;
            kill_ex_q   <= kill_ex_d;
            kill_mem_q  <= kill_mem_d;
            mepc_we_q   <= mepc_we_d;
            int_ack_q   <= int_ack_d;
        end
    end

`ifdef OTTER_REDIRECT_CNT_EN
    logic [31:0] redir_cnt_q, int_cnt_q;

    // Count entries into REDIR and INTR; free-running, wraps naturally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            redir_cnt_q <= 32'd0;
            int_cnt_q   <= 32'd0;
        end else begin
            if (redir_accept) redir_cnt_q <= redir_cnt_q + 32'd1;
            if (int_accept)   int_cnt_q   <= int_cnt_q + 32'd1;
        end
    end

    assign REDIR_CNT = redir_cnt_q;
    assign INT_CNT   = int_cnt_q;
`endif

    assign bus.PC        = pc_q;
    assign bus.PC_PLUS4  = pc_q + 32'd4;
    assign bus.KILL_ID   = kill_id_q;
    assign bus.KILL_EX   = kill_ex_q;
    assign bus.KILL_MEM  = kill_mem_q;
    assign bus.MEPC_WE   = mepc_we_q;
    assign bus.MEPC_DATA = mepc_data_q;
    assign bus.INT_ACK   = int_ack_q;
    assign bus.BUSY      = (state_q != ST_RUN);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then random traffic.
module tb_pc_redirect_ctrl;
    localparam logic [31:0] RV = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_redirect_ctrl_if bus();
`ifdef OTTER_REDIRECT_CNT_EN
    logic [31:0] redir_cnt, int_cnt;
`endif

    pc_redirect_ctrl #(.RESET_VEC(RV)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
`ifdef OTTER_REDIRECT_CNT_EN
        ,
        .REDIR_CNT (redir_cnt),
        .INT_CNT   (int_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  kills;
        logic        we;
        logic        ack;
        logic        busy;
        logic [31:0] mdata;
        logic [31:0] rc;
        logic [31:0] ic;
    } exp_t;

    exp_t sb[$];

    // Reference model: a transfer blocks the very next cycle from taking another.
    logic [31:0] m_pc, m_mdata, m_rc, m_ic;
    bit          m_blocked;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] src_target(input logic [2:0] s);
        case (s)
            3'd1:    return bus.JALR_TGT;
            3'd2:    return bus.BRANCH_TGT;
            3'd3:    return bus.JAL_TGT;
            3'd5:    return bus.MEPC_IN;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_transfer(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd5);
    endfunction

    task automatic model_reset();
        m_pc      = RV;
        m_mdata   = 32'd0;
        m_rc      = 32'd0;
        m_ic      = 32'd0;
        m_blocked = 1'b0;
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.kills = 3'b000; e.we = 1'b0; e.ack = 1'b0; e.busy = 1'b0;
        if (!m_blocked && bus.EX_VALID && bus.INT_TAKEN) begin
            m_pc      = bus.MTVEC & ~32'd3;
            m_mdata   = bus.EX_PC;
            m_ic      = m_ic + 1;
            e.kills   = 3'b111; e.we = 1'b1; e.ack = 1'b1; e.busy = 1'b1;
            m_blocked = 1'b1;
        end else if (!m_blocked && bus.EX_VALID && is_transfer(bus.PC_SOURCE)) begin
            m_pc      = src_target(bus.PC_SOURCE) & ~32'd3;
            m_rc      = m_rc + 1;
            e.kills   = 3'b011; e.busy = 1'b1;
            m_blocked = 1'b1;
        end else begin
            if (!bus.STALL) m_pc = m_pc + 32'd4;
            m_blocked = 1'b0;
        end
        e.pc = m_pc; e.mdata = m_mdata; e.rc = m_rc; e.ic = m_ic;
        return e;
    endfunction

    task automatic clear_inputs();
        bus.STALL = 1'b0; bus.EX_VALID = 1'b0; bus.EX_PC = 32'd0;
        bus.PC_SOURCE = 3'd0; bus.INT_TAKEN = 1'b0;
        bus.JALR_TGT = 32'd0; bus.BRANCH_TGT = 32'd0; bus.JAL_TGT = 32'd0;
        bus.MTVEC = 32'd0; bus.MEPC_IN = 32'd0;
    endtask

    // Apply current inputs for one clock; expectation enters the queue after the edge.
    task automatic cycle();
        exp_t e;
        e = predict();
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"},    bus.PC, RV);
        chk({tag, "_kills"}, {29'd0, bus.KILL_MEM, bus.KILL_EX, bus.KILL_ID}, 32'd0);
        chk({tag, "_we"},    {31'd0, bus.MEPC_WE}, 32'd0);
        chk({tag, "_ack"},   {31'd0, bus.INT_ACK}, 32'd0);
        chk({tag, "_mdata"}, bus.MEPC_DATA, 32'd0);
        chk({tag, "_busy"},  {31'd0, bus.BUSY}, 32'd0);
`ifdef OTTER_REDIRECT_CNT_EN
        chk({tag, "_rcnt"},  redir_cnt, 32'd0);
        chk({tag, "_icnt"},  int_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: every expectation is checked at the falling edge after its update.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc",       bus.PC, e.pc);
                chk("pc_plus4", bus.PC_PLUS4, e.pc + 32'd4);
                chk("kills",    {29'd0, bus.KILL_MEM, bus.KILL_EX, bus.KILL_ID}, {29'd0, e.kills});
                chk("mepc_we",  {31'd0, bus.MEPC_WE}, {31'd0, e.we});
                chk("int_ack",  {31'd0, bus.INT_ACK}, {31'd0, e.ack});
                chk("busy",     {31'd0, bus.BUSY}, {31'd0, e.busy});
                if (e.we) chk("mepc_data", bus.MEPC_DATA, e.mdata);
`ifdef OTTER_REDIRECT_CNT_EN
                chk("redir_cnt", redir_cnt, e.rc);
                chk("int_cnt",   int_cnt, e.ic);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        model_reset();
        #3;
        do_reset();

        // Sequential fetch out of reset.
        repeat (3) cycle();

        // Taken branch, then a JAL on the wrong path that must be ignored.
        bus.EX_VALID = 1'b1; bus.PC_SOURCE = 3'd2; bus.BRANCH_TGT = 32'h240;
        cycle();
        bus.PC_SOURCE = 3'd3; bus.JAL_TGT = 32'h500;
        cycle();
        clear_inputs();
        cycle();

        // JALR alignment overriding a stall, then a stalled REDIR cycle.
        bus.STALL = 1'b1; bus.EX_VALID = 1'b1; bus.PC_SOURCE = 3'd1; bus.JALR_TGT = 32'h303;
        cycle();
        bus.EX_VALID = 1'b0;
        cycle();
        clear_inputs();
        cycle();

        // Interrupt beats a simultaneous branch.
        bus.EX_VALID = 1'b1; bus.INT_TAKEN = 1'b1; bus.PC_SOURCE = 3'd2;
        bus.BRANCH_TGT = 32'h444; bus.EX_PC = 32'h58; bus.MTVEC = 32'h800;
        cycle();
        clear_inputs();
        cycle();

        // Interrupt raised during REDIR is deferred, then MRET returns.
        bus.EX_VALID = 1'b1; bus.PC_SOURCE = 3'd2; bus.BRANCH_TGT = 32'h400;
        bus.MTVEC = 32'h803; bus.EX_PC = 32'h58;
        cycle();
        bus.INT_TAKEN = 1'b1; bus.PC_SOURCE = 3'd0;
        cycle();
        cycle();
        bus.INT_TAKEN = 1'b0; bus.EX_VALID = 1'b0;
        cycle();
        bus.EX_VALID = 1'b1; bus.PC_SOURCE = 3'd5; bus.MEPC_IN = 32'h58;
        cycle();
        clear_inputs();
        cycle();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bus.STALL      = ($urandom_range(0, 3) == 0);
            bus.EX_VALID   = ($urandom_range(0, 3) != 0);
            bus.PC_SOURCE  = 3'($urandom_range(0, 7));
            bus.INT_TAKEN  = ($urandom_range(0, 9) == 0);
            bus.EX_PC      = $urandom;
            bus.JALR_TGT   = $urandom;
            bus.BRANCH_TGT = $urandom;
            bus.JAL_TGT    = $urandom;
            bus.MTVEC      = $urandom;
            bus.MEPC_IN    = $urandom;
            cycle();
        end
        clear_inputs();
        cycle();

        // Fresh reset, three redirects and one interrupt, then reset mid-INTR.
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.EX_VALID = 1'b1; bus.PC_SOURCE = 3'd3; bus.JAL_TGT = 32'h1000 + 32'(k * 16);
            cycle();
            clear_inputs();
            cycle();
        end
        bus.EX_VALID = 1'b1; bus.INT_TAKEN = 1'b1; bus.EX_PC = 32'h2468; bus.MTVEC = 32'h900;
        cycle();
        clear_inputs();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midintr_reset");
        sb.delete();
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        repeat (2) cycle();

        repeat (2) @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
